// File: rtl/tone_player.sv
// rtl/tone_player.sv - square-wave note player with a one-entry command holding buffer
// Each command is {pitch[7:4], duration[3:0]}; pitch 0 is a rest, duration 0 is dropped.
module tone_player #(
  parameter int BASE_HALF   = 28409,
  parameter int STEP_HALF   = 5000,
  parameter int UNIT_CYCLES = 5000000,
  parameter int CNT_W       = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sound,
  input  logic       sound_valid,
  output logic       sound_ready,
  input  logic       stop,
  output logic       speaker,
  output logic       busy,
  output logic       note_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TONE = 2'd1;
  localparam logic [1:0] S_REST = 2'd2;

  localparam logic [CNT_W-1:0] BASE_C    = CNT_W'(BASE_HALF);
  localparam logic [CNT_W-1:0] STEP_C    = CNT_W'(STEP_HALF);
  localparam logic [CNT_W-1:0] UNIT_LAST = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [7:0]       buf_q, buf_d;
  logic             buf_full_q, buf_full_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] half_cnt_q, half_cnt_d;
  logic [CNT_W-1:0] unit_cnt_q, unit_cnt_d;
  logic [3:0]       units_q, units_d;
  logic [3:0]       dur_q, dur_d;
  logic             speaker_q, speaker_d;
  logic             accept, last_cycle, load;
  logic [7:0]       load_cmd;

  function automatic logic [CNT_W-1:0] half_of(input logic [3:0] p);
    return BASE_C + CNT_W'(4'd15 - p) * STEP_C;
  endfunction

  assign sound_ready = !buf_full_q;
  assign busy        = (state_q != S_IDLE);
  assign speaker     = speaker_q;
  assign accept      = sound_valid && sound_ready && (sound[3:0] != 4'd0);
  assign last_cycle  = busy && (unit_cnt_q == UNIT_LAST) && (units_q == dur_q - 4'd1);
  assign note_done   = last_cycle;

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    half_d     = half_q;
    half_cnt_d = half_cnt_q;
    unit_cnt_d = unit_cnt_q;
    units_d    = units_q;
    dur_d      = dur_q;
    speaker_d  = speaker_q;
    load       = 1'b0;
    load_cmd   = sound;
    if (stop) begin
      state_d    = S_IDLE;
      buf_full_d = 1'b0;
      speaker_d  = 1'b0;
    end else if (!busy) begin
      load = accept;
    end else if (last_cycle) begin
      // The buffered note wins over a fresh handshake so order is preserved.
      if (buf_full_q) begin
        load       = 1'b1;
        load_cmd   = buf_q;
        buf_full_d = 1'b0;
      end else if (accept) begin
        load = 1'b1;
      end else begin
        state_d   = S_IDLE;
        speaker_d = 1'b0;
      end
    end else begin
      if (unit_cnt_q == UNIT_LAST) begin
        unit_cnt_d = '0;
        units_d    = units_q + 4'd1;
      end else begin
        unit_cnt_d = unit_cnt_q + ONE_C;
      end
      if (state_q == S_TONE) begin
        if (half_cnt_q == half_q - ONE_C) begin
          half_cnt_d = '0;
          speaker_d  = !speaker_q;
        end else begin
          half_cnt_d = half_cnt_q + ONE_C;
        end
      end
      if (accept) begin
        buf_d      = sound;
        buf_full_d = 1'b1;
      end
    end
    if (load) begin
      state_d    = (load_cmd[7:4] == 4'd0) ? S_REST : S_TONE;
      half_d     = half_of(load_cmd[7:4]);
      half_cnt_d = '0;
      unit_cnt_d = '0;
      units_d    = 4'd0;
      dur_d      = load_cmd[3:0];
      speaker_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      buf_q      <= 8'd0;
      buf_full_q <= 1'b0;
      half_q     <= '0;
      half_cnt_q <= '0;
      unit_cnt_q <= '0;
      units_q    <= 4'd0;
      dur_q      <= 4'd0;
      speaker_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      half_q     <= half_d;
      half_cnt_q <= half_cnt_d;
      unit_cnt_q <= unit_cnt_d;
      units_q    <= units_d;
      dur_q      <= dur_d;
      speaker_q  <= speaker_d;
    end
  end

endmodule

// File: tb/tb_tone_player.sv
// tb/tb_tone_player.sv - directed and randomized bench for tone_player
// The reference model tracks elapsed time per note and derives outputs arithmetically.
module tb_tone_player;

  localparam int BH = 4;
  localparam int SH = 1;
  localparam int UC = 20;

  logic       clk;
  logic       reset;
  logic [7:0] sound;
  logic       sound_valid;
  logic       sound_ready;
  logic       stop;
  logic       speaker;
  logic       busy;
  logic       note_done;

  tone_player #(.BASE_HALF(BH), .STEP_HALF(SH), .UNIT_CYCLES(UC), .CNT_W(24)) dut (
    .clk(clk), .reset(reset), .sound(sound), .sound_valid(sound_valid),
    .sound_ready(sound_ready), .stop(stop), .speaker(speaker), .busy(busy),
    .note_done(note_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // reference model: current note, elapsed cycles, one-entry buffer
  bit         m_busy;
  int         m_p, m_d, m_t;
  bit         m_buf_full;
  logic [7:0] m_buf;
  bit         hs_seen;

  int cyc, rises, busy_cyc, high_cyc, done_cnt;
  bit prev_spk;
  int done_at[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_out();
    int  h;
    bit  spk, done;
    h    = BH + (15 - m_p) * SH;
    spk  = m_busy && (m_p != 0) && (((m_t / h) % 2) == 1);
    done = m_busy && (m_t == m_d * UC - 1);
    return {m_busy, spk, !m_buf_full, done};
  endfunction

  task automatic model_clear();
    m_busy = 0; m_p = 0; m_d = 0; m_t = 0; m_buf_full = 0; m_buf = 8'd0;
  endtask

  task automatic start_note(input logic [7:0] c);
    m_busy = 1; m_p = int'(c[7:4]); m_d = int'(c[3:0]); m_t = 0;
  endtask

  task automatic clr_stats();
    rises = 0; busy_cyc = 0; high_cyc = 0; done_cnt = 0; done_at.delete();
  endtask

  task automatic tick();
    bit acc;
    hs_seen = sound_valid && !m_buf_full;
    acc = hs_seen && (sound[3:0] != 4'd0);
    if (stop) begin
      m_busy = 0; m_buf_full = 0;
    end else if (!m_busy) begin
      if (acc) start_note(sound);
    end else if (m_t == m_d * UC - 1) begin
      if (m_buf_full) begin
        start_note(m_buf); m_buf_full = 0;
      end else if (acc) begin
        start_note(sound);
      end else begin
        m_busy = 0;
      end
    end else begin
      m_t++;
      if (acc) begin m_buf = sound; m_buf_full = 1; end
    end
    @(posedge clk);
    #1;
    check("outputs{busy,spk,ready,done}", {28'd0, busy, speaker, sound_ready, note_done}, {28'd0, exp_out()});
    cyc++;
    if (speaker && !prev_spk) rises++;
    prev_spk = speaker;
    if (busy) busy_cyc++;
    if (speaker) high_cyc++;
    if (note_done) begin done_cnt++; done_at.push_back(cyc); end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [7:0] c);
    bit got;
    got = 0;
    sound = c; sound_valid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      tick();
      got = hs_seen;
    end
    sound_valid = 1'b0;
    check("send_handshake_within_budget", {31'd0, got}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; sound = 8'd0; sound_valid = 1'b0; stop = 1'b0;
    model_clear(); cyc = 0; prev_spk = 0; clr_stats();
    @(posedge clk); #1;
    check("reset_state", {28'd0, busy, speaker, sound_ready, note_done}, 32'b0010);
    reset = 1'b0;
    run(3);

    // single tone p=15 d=2
    clr_stats();
    send(8'hF2);
    run(45);
    check("single_rises", rises, 5);
    check("single_busy_cycles", busy_cyc, 40);
    check("single_done_pulses", done_cnt, 1);
    check("single_idle_speaker", {31'd0, speaker}, 32'd0);

    // pitch arithmetic p=11 d=1 -> half-period 8
    clr_stats();
    send(8'hB1);
    run(25);
    check("pitch11_high_cycles", high_cyc, 8);
    check("pitch11_busy_cycles", busy_cyc, 20);

    // chained notes, third held off while buffer full
    clr_stats();
    send(8'hF1);
    send(8'h01);
    check("chain_ready_low_when_buffered", {31'd0, sound_ready}, 32'd0);
    send(8'hE1);
    run(70);
    check("chain_done_pulses", done_cnt, 3);
    check("chain_busy_cycles", busy_cyc, 60);
    if (done_at.size() >= 3) begin
      check("chain_gap_1", done_at[1] - done_at[0], 20);
      check("chain_gap_2", done_at[2] - done_at[1], 20);
    end

    // stop with buffer full and valid asserted
    send(8'hF3);
    send(8'h12);
    run(5);
    sound = 8'h21; sound_valid = 1'b1; stop = 1'b1;
    tick();
    sound_valid = 1'b0; stop = 1'b0;
    check("stop_full_state", {28'd0, busy, speaker, sound_ready, note_done}, 32'b0010);
    clr_stats();
    run(80);
    check("stop_full_nothing_after", busy_cyc + done_cnt, 0);

    // stop coinciding with a real handshake
    send(8'hF3);
    run(3);
    check("stop_hs_ready_before", {31'd0, sound_ready}, 32'd1);
    sound = 8'h21; sound_valid = 1'b1; stop = 1'b1;
    tick();
    sound_valid = 1'b0; stop = 1'b0;
    clr_stats();
    run(30);
    check("stop_hs_dropped", busy_cyc + done_cnt, 0);

    // zero-duration command
    clr_stats();
    send(8'hF0);
    run(5);
    check("d0_no_busy", busy_cyc, 0);
    check("d0_no_done", done_cnt, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      sound_valid = ($urandom_range(2, 0) == 0);
      sound = {4'($urandom_range(15, 0)), 4'($urandom_range(2, 0))};
      stop = ($urandom_range(63, 0) == 0);
      tick();
    end
    sound_valid = 1'b0; stop = 1'b0;
    run(100);

    // asynchronous reset mid-tone
    send(8'hF2);
    run(6);
    check("pre_reset_speaker_high", {31'd0, speaker}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_clears", {28'd0, busy, speaker, sound_ready, note_done}, 32'b0010);
    model_clear();
    @(posedge clk); #1;
    reset = 1'b0;
    prev_spk = 0;
    run(5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/tone_player.md
# tone_player

Speaker note player that consumes the 8-bit sound commands emitted by the display logic and drives the single-bit `speaker` pin with a square wave. Each command is one note or rest: a pitch index and a duration. A one-entry holding buffer lets the producer queue the next note while the current one sounds, so melodies (spin click, win jingle) play back-to-back with no gap. It sits between the display block's `sound` output and the board's `speaker` pin, clocked from the main `clk`.

## Interface
- `BASE_HALF`, 28409: half-period in `clk` cycles for pitch index 15 (~1760 Hz at 100 MHz).
- `STEP_HALF`, 5000: additional half-period cycles per pitch step below 15.
- `UNIT_CYCLES`, 5000000: cycles per duration unit (50 ms at 100 MHz).
- `CNT_W`, 24: width of all internal counters; must hold `BASE_HALF+15*STEP_HALF` and `UNIT_CYCLES`.
- `clk` in 1: single clock, all logic on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `sound` in 8: command; [7:4] pitch index p (0 = rest), [3:0] duration d in units.
- `sound_valid` in 1: `sound` holds a command.
- `sound_ready` out 1: holding buffer empty; a command is accepted on any edge where valid && ready.
- `stop` in 1: abort the current note and flush the buffer.
- `speaker` out 1: square-wave output.
- `busy` out 1: a note or rest is in progress.
- `note_done` out 1: one-cycle pulse when a note/rest completes its full duration.

## Operation
- Reset values: `speaker`=0, `busy`=0, `sound_ready`=1, `note_done`=0; state IDLE; buffer empty.
- States: IDLE, TONE (p≠0), REST (p=0). `busy`=1 in TONE/REST.
- `sound_ready` = buffer empty. It is a registered-state decode with no combinational path from `sound_valid`.
- Half-period h = `BASE_HALF` + (15−p)·`STEP_HALF`, computed at `CNT_W` bits and latched at note start.
- Accept with d=0: the handshake completes and the command is dropped. No state change, no `note_done`.
- Accept in IDLE: the command loads directly as the current note. Next state is TONE or REST.
- Accept in TONE/REST: the command is stored in the buffer and `sound_ready` drops.
- Note start: half counter cleared, unit counter and unit count cleared, `speaker`=0.
- TONE: the half counter increments each cycle. On reaching h−1 it clears and `speaker` toggles.
- REST: `speaker` is held at 0.
- Note length is exactly d·`UNIT_CYCLES` cycles. On the final cycle:
  - `note_done` pulses.
  - If the buffer is full, the buffered note becomes current (fresh start) and the buffer empties.
  - Otherwise, if a command is accepted on that same edge, it becomes current directly.
  - Otherwise the block returns to IDLE with `speaker`=0.
- `stop`: on the next edge, state becomes IDLE, buffer empties, `speaker`=0, no `note_done`. `stop` has priority over a simultaneous handshake, and that command is dropped.
- `reset` mid-note: all outputs immediately return to their reset values.

## Timing
- Accept in IDLE at edge k: `busy`=1 and `speaker`=0 from edge k. The first `speaker` rise is at edge k+h, then it toggles every h cycles.
- `note_done` is high for the cycle following edge k+d·`UNIT_CYCLES`−1.
- A buffered note starts on that same edge: zero idle cycles between notes.
- `sound_ready` returns to 1 on the edge the buffer drains. The producer sees ready one cycle after a chained start.
- `stop` latency: 1 edge.

## Test plan
Bench parameters for all scenarios: `BASE_HALF`=4, `STEP_HALF`=1, `UNIT_CYCLES`=20.
- Single tone: send p=15, d=2 from IDLE -> `speaker` period 8 cycles, exactly 5 rising edges, `busy` high 40 cycles, one `note_done` pulse, then IDLE with `speaker`=0.
- Pitch arithmetic: p=11, d=1 -> half-period 8, `speaker` high 8 / low 8 cycles, 20-cycle note.
- Chained notes: send p=15 d=1, then immediately p=0 d=1, then p=14 d=1 -> the second command is buffered and `sound_ready`=0 until the first note ends. The rest follows with no gap (`speaker`=0 for 20 cycles). Three `note_done` pulses 20 cycles apart.
- Third command while the buffer is full -> `sound_ready`=0 and the command is held off until the buffer drains. No command is lost or duplicated.
- `stop` asserted on the same edge as a handshake, mid-note with the buffer full -> next cycle IDLE, `speaker`=0, `sound_ready`=1, no `note_done`, nothing plays afterward.
- d=0 command -> accepted, no `busy`, no pulse. Asynchronous `reset` mid-tone -> `speaker`/`busy` clear without waiting for a clock edge.
